sram_ring_arbiter: RTL and testbench
====================================

// Module: sram_ring_arbiter
// PURPOSE
//  Sequences a single-port SRAM shared by two requesters: the FIFO-drain writer
//  (fifo_to_sram: sram_start/sram_data_out, data_done) and an SRAM-to-FIFO reader.
//  Keeps the SRAM as a ring buffer with write/read pointers and an occupancy count.
//  Arbitrates round-robin, runs fixed-length access cycles and returns done pulses.
// PARAMETERS
//  AW          10  SRAM address width; ring depth DEPTH = 2**AW words
//  DW          32  data width
//  WAIT_STATES 1   extra cycles per access (access length = WAIT_STATES+1)
// PORTS
//  wb_clk      in   1   single clock, all logic on posedge
//  wb_rst      in   1   reset, synchronous, active-low
//  wr_start    in   1   1-cycle write request pulse (from fifo_to_sram sram_start)
//  wr_data     in   DW  write data, sampled in the wr_start cycle
//  wr_done     out  1   1-cycle pulse: write committed (to fifo_to_sram data_done)
//  rd_start    in   1   1-cycle read request pulse
//  rd_data     out  DW  read data, valid when rd_done is high, held until next read
//  rd_done     out  1   1-cycle pulse: rd_data valid
//  sram_ce     out  1   SRAM chip enable, high for whole access
//  sram_we     out  1   SRAM write enable, high for whole write access
//  sram_addr   out  AW  SRAM address
//  sram_wdata  out  DW  SRAM write data
//  sram_rdata  in   DW  SRAM read data, sampled in last access cycle
//  level       out  AW+1 words stored, 0..DEPTH
//  full        out  1   level == DEPTH
//  empty       out  1   level == 0
// BEHAVIOUR
//  - Reset (wb_rst==0 at posedge): all outputs 0 except empty=1; pointers, level,
//    pending flags, last-grant (=READ) cleared; state IDLE. Mid-access reset
//    aborts: ce/we low after that edge, no done pulse, no pointer update.
//  - wr_start sets wr_pend and latches wr_data; rd_start sets rd_pend. A start
//    on a channel already pending is ignored (data not re-latched).
//  - Eligibility: write eligible = wr_pend & ~full; read = rd_pend & ~empty.
//    Ineligible requests stay pending (write waits for space, read for data).
//  - FSM IDLE -> ACCESS -> DONE -> IDLE:
//    IDLE: if both eligible grant channel != last grant; else grant the eligible
//      one; none -> stay. Grant registers addr (wr_ptr or rd_ptr), wdata, we.
//    ACCESS: ce=1 (we=1 for write) for exactly WAIT_STATES+1 cycles, counter
//      counts down; read samples sram_rdata into rd_data in last cycle.
//    DONE: ce=we=0; wr_done or rd_done pulses 1 cycle; pointer += 1 mod DEPTH
//      (natural AW-bit wrap); level +1 (write) / -1 (read); pend cleared;
//      last grant updated. A start for the same channel in DONE is accepted.
//  - Minimum per-transfer latency start->done = WAIT_STATES+3 cycles.
//  - Write never proceeds when full, read never when empty; level never
//    over/underflows. wr_ptr==rd_ptr is disambiguated by level.
// CONFIGURATION
//  SRAM_ARB_STATS_EN defined: adds outputs wr_stall_cnt and rd_stall_cnt (16 b
//    each): count cycles a channel is pending but not granted; saturate at
//    16'hFFFF; cleared by reset only.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: hold wb_rst=0 3 cycles -> ce=we=0, done=0, level=0, empty=1, full=0.
//  2 Write 32'hA5B6C7D8 then read, WAIT_STATES=1 -> sram_addr=0 with we=1 for
//    2 cycles, wr_done at start+4; read rd_data=32'hA5B6C7D8, level back to 0.
//  3 Simultaneous wr_start/rd_start with level=2 after reset -> write granted
//    first (last grant=READ), then read; next tie grants write again.
//  4 Read while empty -> no ce, no rd_done; later write 32'h55555555 -> write
//    completes, then pending read returns 32'h55555555.
//  5 Fill AW=2 ring with 4 writes -> full=1; 5th wr_start held, no wr_done until
//    a read completes; 5th word lands at addr 0 (wrap), level stays 4.
//  6 Assert reset mid-access -> ce low next cycle, no done, level unchanged=0;
//    with SRAM_ARB_STATS_EN: stall counters read 0 after reset.

Source files
------------

// File: rtl/sram_ring_arbiter.sv
// sram_ring_arbiter: single-port SRAM used as a ring buffer, shared by a
// write channel (FIFO drain) and a read channel. Round-robin arbitration,
// fixed-length accesses of WAIT_STATES+1 cycles, one-cycle done pulses.
// Optional feature macro: SRAM_ARB_STATS_EN adds per-channel stall counters.
module sram_ring_arbiter #(
  parameter int unsigned AW          = 10,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          wr_start,
  input  logic [DW-1:0] wr_data,
  output logic          wr_done,
  input  logic          rd_start,
  output logic [DW-1:0] rd_data,
  output logic          rd_done,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]   wr_stall_cnt,
  output logic [15:0]   rd_stall_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          wr_pend, wr_pend_n;
  logic          rd_pend, rd_pend_n;
  logic [DW-1:0] wr_buf, wr_buf_n;
  logic          last_wr, last_wr_n;   // 0 = last grant was READ
  logic          cur_wr, cur_wr_n;     // channel of the access in flight
  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [AW:0]   level_n;
  logic          full_n, empty_n;
  logic          ce_n, we_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n, rdata_n;
  logic          wr_done_n, rd_done_n;
  logic          wr_elig, rd_elig, grant_wr, grant_rd;

  // Eligibility and round-robin grant decision (only meaningful in IDLE)
  always_comb begin
    wr_elig  = wr_pend & ~full;
    rd_elig  = rd_pend & ~empty;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE) begin
      grant_wr = wr_elig & (~rd_elig | ~last_wr);
      grant_rd = rd_elig & ~grant_wr;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    wr_pend_n = wr_pend;
    rd_pend_n = rd_pend;
    wr_buf_n  = wr_buf;
    last_wr_n = last_wr;
    cur_wr_n  = cur_wr;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    level_n   = level;
    ce_n      = sram_ce;
    we_n      = sram_we;
    addr_n    = sram_addr;
    wdata_n   = sram_wdata;
    rdata_n   = rd_data;
    wr_done_n = 1'b0;
    rd_done_n = 1'b0;

    // A start on an already pending channel is dropped, data not re-latched
    if (wr_start && !wr_pend) begin
      wr_pend_n = 1'b1;
      wr_buf_n  = wr_data;
    end
    if (rd_start && !rd_pend) begin
      rd_pend_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (grant_wr) begin
          state_n  = ACCESS;
          cur_wr_n = 1'b1;
          ce_n     = 1'b1;
          we_n     = 1'b1;
          addr_n   = wr_ptr;
          wdata_n  = wr_buf;
          cnt_n    = CW'(WAIT_STATES);
        end else if (grant_rd) begin
          state_n  = ACCESS;
          cur_wr_n = 1'b0;
          ce_n     = 1'b1;
          we_n     = 1'b0;
          addr_n   = rd_ptr;
          cnt_n    = CW'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          // Last access cycle: commit so DONE shows the updated ring state
          state_n = DONE;
          ce_n    = 1'b0;
          we_n    = 1'b0;
          if (cur_wr) begin
            wr_done_n = 1'b1;
            wr_ptr_n  = wr_ptr + AW'(1);
            level_n   = level + (AW+1)'(1);
            wr_pend_n = 1'b0;
            last_wr_n = 1'b1;
          end else begin
            rd_done_n = 1'b1;
            rdata_n   = sram_rdata;
            rd_ptr_n  = rd_ptr + AW'(1);
            level_n   = level - (AW+1)'(1);
            rd_pend_n = 1'b0;
            last_wr_n = 1'b0;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        ce_n    = 1'b0;
        we_n    = 1'b0;
      end
    endcase

    full_n  = (level_n == (AW+1)'(DEPTH));
    empty_n = (level_n == '0);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_pend    <= 1'b0;
      rd_pend    <= 1'b0;
      wr_buf     <= '0;
      last_wr    <= 1'b0;
      cur_wr     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rd_data    <= '0;
      wr_done    <= 1'b0;
      rd_done    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      wr_pend    <= wr_pend_n;
      rd_pend    <= rd_pend_n;
      wr_buf     <= wr_buf_n;
      last_wr    <= last_wr_n;
      cur_wr     <= cur_wr_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      level      <= level_n;
      full       <= full_n;
      empty      <= empty_n;
      sram_ce    <= ce_n;
      sram_we    <= we_n;
      sram_addr  <= addr_n;
      sram_wdata <= wdata_n;
      rd_data    <= rdata_n;
      wr_done    <= wr_done_n;
      rd_done    <= rd_done_n;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic wr_stall, rd_stall;

  // A channel stalls when pending and neither granted nor being serviced
  always_comb begin
    wr_stall = wr_pend & ~grant_wr & ~((state == ACCESS) & cur_wr);
    rd_stall = rd_pend & ~grant_rd & ~((state == ACCESS) & ~cur_wr);
  end

  // Saturating stall counters, cleared by reset only
  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      wr_stall_cnt <= '0;
      rd_stall_cnt <= '0;
    end else begin
      if (wr_stall && (wr_stall_cnt != 16'hFFFF)) wr_stall_cnt <= wr_stall_cnt + 16'd1;
      if (rd_stall && (rd_stall_cnt != 16'hFFFF)) rd_stall_cnt <= rd_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_ring_arbiter.sv
// Testbench for sram_ring_arbiter: AW=2 ring, DW=32, WAIT_STATES=1.
// Write data goes into a scoreboard queue when driven; each rd_done pops it.
module tb_sram_ring_arbiter;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned WS = 1;

  logic          clk = 1'b0;
  logic          wb_rst = 1'b0;
  logic          wr_start = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_done;
  logic          rd_start = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_done;
  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic [AW:0]   level;
  logic          full, empty;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]   wr_stall_cnt, rd_stall_cnt;
`endif

  sram_ring_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(WS)) dut (
    .wb_clk     (clk),
    .wb_rst     (wb_rst),
    .wr_start   (wr_start),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .rd_start   (rd_start),
    .rd_data    (rd_data),
    .rd_done    (rd_done),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .level      (level),
    .full       (full),
    .empty      (empty)
`ifdef SRAM_ARB_STATS_EN
    ,
    .wr_stall_cnt (wr_stall_cnt),
    .rd_stall_cnt (rd_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: synchronous write, asynchronous read
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (sram_ce && sram_we) mem[sram_addr] <= sram_wdata;
  assign sram_rdata = mem[sram_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_done_cnt = 0, rd_done_cnt = 0;
  int wr_done_cyc = 0, rd_done_cyc = 0;
  int ce_cycles = 0, we_cycles = 0;
  logic [AW-1:0] last_we_addr = '0;
  logic ce_prev = 1'b0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_head;
  bit grant_log [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor and scoreboard comparison
  always @(negedge clk) begin
    if (sram_ce && !ce_prev) grant_log.push_back(sram_we);
    if (sram_ce) begin
      ce_cycles++;
      if (sram_we) begin
        we_cycles++;
        last_we_addr = sram_addr;
      end
    end
    ce_prev = sram_ce;
    if (wr_done) begin
      wr_done_cnt++;
      wr_done_cyc = cyc;
    end
    if (rd_done) begin
      rd_done_cnt++;
      rd_done_cyc = cyc;
      if (exp_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
      else begin
        exp_head = exp_q.pop_front();
        check("rd_data_sb", 64'(rd_data), 64'(exp_head));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wb_rst = 1'b0;
    wr_start = 1'b0;
    rd_start = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    grant_log.delete();
    wb_rst = 1'b1;
  endtask

  task automatic pulse_wr(input logic [DW-1:0] d);
    wr_start = 1'b1;
    wr_data  = d;
    exp_q.push_back(d);
    tick();
    wr_start = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_wr(input int target, input string tag);
    int t = 0;
    while (wr_done_cnt < target && t < 40) begin tick(); t++; end
    check(tag, 64'(wr_done_cnt >= target), 64'd1);
  endtask

  task automatic wait_rd(input int target, input string tag);
    int t = 0;
    while (rd_done_cnt < target && t < 40) begin tick(); t++; end
    check(tag, 64'(rd_done_cnt >= target), 64'd1);
  endtask

  initial begin
    int c0, n_wr, n_rd, n_ce, t;

    // 1: reset values
    do_reset();
    wb_rst = 1'b0;
    tick();
    check("rst_ce", 64'(sram_ce), 64'd0);
    check("rst_we", 64'(sram_we), 64'd0);
    check("rst_done", 64'({wr_done, rd_done}), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    wb_rst = 1'b1;

    // 2: write then read, latency and addressing
    we_cycles = 0;
    c0 = cyc;
    pulse_wr(32'hA5B6C7D8);
    wait_wr(1, "t2_wr_timeout");
    check("t2_wr_lat", 64'(wr_done_cyc), 64'(c0 + 4));
    check("t2_we_cycles", 64'(we_cycles), 64'd2);
    check("t2_we_addr", 64'(last_we_addr), 64'd0);
    check("t2_level1", 64'(level), 64'd1);
    c0 = cyc;
    pulse_rd();
    wait_rd(1, "t2_rd_timeout");
    check("t2_rd_lat", 64'(rd_done_cyc), 64'(c0 + 4));
    check("t2_rd_data", 64'(rd_data), 64'hA5B6C7D8);
    check("t2_level0", 64'(level), 64'd0);
    check("t2_empty", 64'(empty), 64'd1);

    // 3: round-robin ties, level=2 with last grant READ
    do_reset();
    n_wr = wr_done_cnt; n_rd = rd_done_cnt;
    for (int i = 0; i < 3; i++) begin
      pulse_wr(32'h3000_0000 + i);
      wait_wr(n_wr + i + 1, "t3_fill_timeout");
    end
    pulse_rd();
    wait_rd(n_rd + 1, "t3_rd_timeout");
    check("t3_level2", 64'(level), 64'd2);
    grant_log.delete();
    for (int k = 0; k < 2; k++) begin
      wr_start = 1'b1; rd_start = 1'b1; wr_data = 32'h3300_0000 + k;
      exp_q.push_back(32'h3300_0000 + k);
      tick();
      wr_start = 1'b0; rd_start = 1'b0;
      wait_wr(n_wr + 4 + k, "t3_tie_wr_timeout");
      wait_rd(n_rd + 2 + k, "t3_tie_rd_timeout");
    end
    check("t3_grants", 64'(grant_log.size()), 64'd4);
    check("t3_g0_write", 64'(grant_log[0]), 64'd1);
    check("t3_g1_read", 64'(grant_log[1]), 64'd0);
    check("t3_g2_write", 64'(grant_log[2]), 64'd1);
    check("t3_g3_read", 64'(grant_log[3]), 64'd0);
    check("t3_level_end", 64'(level), 64'd2);

    // 4: read while empty waits for data
    do_reset();
    n_wr = wr_done_cnt; n_rd = rd_done_cnt; n_ce = ce_cycles;
    pulse_rd();
    repeat (10) tick();
    check("t4_no_rd_done", 64'(rd_done_cnt), 64'(n_rd));
    check("t4_no_ce", 64'(ce_cycles), 64'(n_ce));
    pulse_wr(32'h55555555);
    wait_wr(n_wr + 1, "t4_wr_timeout");
    wait_rd(n_rd + 1, "t4_rd_timeout");
    check("t4_rd_data", 64'(rd_data), 64'h55555555);
    check("t4_level", 64'(level), 64'd0);

    // 5: fill the ring, blocked write, wrap to address 0
    do_reset();
    n_wr = wr_done_cnt; n_rd = rd_done_cnt;
    for (int i = 0; i < 4; i++) begin
      pulse_wr(32'h5000_0000 + i);
      wait_wr(n_wr + i + 1, "t5_fill_timeout");
    end
    check("t5_full", 64'(full), 64'd1);
    check("t5_level4", 64'(level), 64'd4);
    pulse_wr(32'h5000_0004);
    repeat (10) tick();
    check("t5_wr_blocked", 64'(wr_done_cnt), 64'(n_wr + 4));
    check("t5_level_held", 64'(level), 64'd4);
    pulse_rd();
    wait_rd(n_rd + 1, "t5_rd_timeout");
    wait_wr(n_wr + 5, "t5_wr5_timeout");
    check("t5_wrap_addr", 64'(last_we_addr), 64'd0);
    check("t5_level_after", 64'(level), 64'd4);
    for (int i = 0; i < 4; i++) begin
      pulse_rd();
      wait_rd(n_rd + 2 + i, "t5_drain_timeout");
    end
    check("t5_drained", 64'(empty), 64'd1);
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    // 6: reset in the middle of an access
    do_reset();
    n_wr = wr_done_cnt;
    pulse_wr(32'h6666_6666);
    t = 0;
    while (!sram_ce && t < 10) begin tick(); t++; end
    check("t6_access_seen", 64'(sram_ce), 64'd1);
    wb_rst = 1'b0;
    tick();
    check("t6_ce_abort", 64'(sram_ce), 64'd0);
`ifdef SRAM_ARB_STATS_EN
    check("t6_wr_stall0", 64'(wr_stall_cnt), 64'd0);
    check("t6_rd_stall0", 64'(rd_stall_cnt), 64'd0);
`endif
    exp_q.delete();
    wb_rst = 1'b1;
    repeat (8) tick();
    check("t6_no_done", 64'(wr_done_cnt), 64'(n_wr));
    check("t6_level", 64'(level), 64'd0);
    check("t6_empty", 64'(empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
